ps2_mouse_ctrl: RTL and testbench

Sequences the PS/2 mouse protocol on top of byte-level PS/2 receive and transmit engines. It issues the reset and enable-reporting commands and checks the device responses, then assembles 3-byte movement packets. The decoded output xm/ym/btnm plus a one-cycle m_done_tick feeds position-counter consumers such as the LED/cursor logic. It owns all retry, timeout and packet-resynchronisation policy.

---
 rtl/ps2_mouse_ctrl_pkg.sv | 53 +++++
 rtl/ps2_mouse_ctrl_timeout_cnt.sv | 41 ++++
 rtl/ps2_mouse_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared constants, state encoding and small decode helpers for the PS/2 mouse sequencer.
package ps2_mouse_ctrl_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_ID_MOUSE  = 8'h00;

  typedef enum logic [3:0] {
    ST_SEND_RST    = 4'd0,
    ST_WAIT_TX_RST = 4'd1,
    ST_WAIT_ACK1   = 4'd2,
    ST_WAIT_BAT    = 4'd3,
    ST_WAIT_ID     = 4'd4,
    ST_SEND_EN     = 4'd5,
    ST_WAIT_TX_EN  = 4'd6,
    ST_WAIT_ACK2   = 4'd7,
    ST_PKT1        = 4'd8,
    ST_PKT2        = 4'd9,
    ST_PKT3        = 4'd10,
    ST_FAIL        = 4'd11
  } state_e;

  function automatic logic [7:0] rsp_of(state_e s);
    case (s)
      ST_WAIT_ACK1: return RSP_ACK;
      ST_WAIT_BAT:  return RSP_BAT_OK;
      ST_WAIT_ID:   return RSP_ID_MOUSE;
      ST_WAIT_ACK2: return RSP_ACK;
      default:      return RSP_ACK;
    endcase
  endfunction

  function automatic state_e rsp_next(state_e s);
    case (s)
      ST_WAIT_ACK1: return ST_WAIT_BAT;
      ST_WAIT_BAT:  return ST_WAIT_ID;
      ST_WAIT_ID:   return ST_SEND_EN;
      ST_WAIT_ACK2: return ST_PKT1;
      default:      return ST_SEND_RST;
    endcase
  endfunction

  // Receiver is muted while we own the bus and once the device is given up on.
  function automatic logic rx_en_of(state_e s);
    case (s)
      ST_SEND_RST, ST_WAIT_TX_RST, ST_SEND_EN, ST_WAIT_TX_EN, ST_FAIL: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_timeout_cnt.sv
// Saturating cycle counter with clear and a selectable terminal count (init timeout vs packet gap).
module ps2_timeout_cnt #(
  parameter int CW    = 26,
  parameter int LIM_A = 50_000_000,
  parameter int LIM_B = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic sel,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] limit_s;

  // next count: clear wins, otherwise count up and stick at the limit
  always_comb begin
    limit_s = sel ? CW'(LIM_B) : CW'(LIM_A);
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q >= limit_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q >= limit_s);

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse protocol sequencer: reset/enable handshake with retries, then 3-byte packet decode.
module ps2_mouse_ctrl #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int GAP_CYC     = 1_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic       rx_en,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       tx_req,
  output logic [7:0] tx_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic       m_done_tick,
  output logic       init_done,
  output logic       err
);
  import ps2_mouse_ctrl_pkg::*;

  localparam int LMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CW   = $clog2(LMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  state_e          state_q, state_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            tx_req_q, tx_req_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rx_en_q, rx_en_d;
  logic            init_done_q, init_done_d;
  logic            err_q, err_d;
  logic [8:0]      xm_q, xm_d;
  logic [8:0]      ym_q, ym_d;
  logic [2:0]      btnm_q, btnm_d;
  logic            m_done_tick_q, m_done_tick_d;
  logic [7:0]      b1_q, b1_d;
  logic [7:0]      b2_q, b2_d;
  logic            fail_s;
  logic            tc_s;
  logic            timer_clr_s;
  logic            gap_sel_s;

  ps2_timeout_cnt #(
    .CW    (CW),
    .LIM_A (TIMEOUT_CYC),
    .LIM_B (GAP_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr_s),
    .sel   (gap_sel_s),
    .tc    (tc_s)
  );

  // next-state, retry policy and output computation
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    tx_req_d      = 1'b0;
    tx_data_d     = tx_data_q;
    init_done_d   = init_done_q;
    err_d         = err_q;
    xm_d          = xm_q;
    ym_d          = ym_q;
    btnm_d        = btnm_q;
    m_done_tick_d = 1'b0;
    b1_d          = b1_q;
    b2_d          = b2_q;
    fail_s        = 1'b0;

    case (state_q)
      ST_SEND_RST, ST_SEND_EN: begin
        if (tx_idle) begin
          tx_req_d  = 1'b1;
          tx_data_d = (state_q == ST_SEND_EN) ? CMD_EN_REPORT : CMD_RESET;
          state_d   = (state_q == ST_SEND_EN) ? ST_WAIT_TX_EN : ST_WAIT_TX_RST;
        end else if (tc_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_TX_RST, ST_WAIT_TX_EN: begin
        if (tx_done_tick) begin
          state_d = (state_q == ST_WAIT_TX_EN) ? ST_WAIT_ACK2 : ST_WAIT_ACK1;
        end else if (tc_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2: begin
        if (rx_done_tick) begin
          if (rx_data == rsp_of(state_q)) begin
            state_d     = rsp_next(state_q);
            init_done_d = (state_q == ST_WAIT_ACK2) ? 1'b1 : init_done_q;
          end else begin
            fail_s = 1'b1;
          end
        end else if (tc_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_PKT1: begin
        // bytes without the always-one bit 3 cannot start a packet
        if (rx_done_tick && rx_data[3]) begin
          b1_d    = rx_data;
          state_d = ST_PKT2;
        end else begin
          state_d = ST_PKT1;
        end
      end
      ST_PKT2: begin
        if (rx_done_tick) begin
          b2_d    = rx_data;
          state_d = ST_PKT3;
        end else if (tc_s) begin
          state_d = ST_PKT1;
        end else begin
          state_d = ST_PKT2;
        end
      end
      ST_PKT3: begin
        if (rx_done_tick) begin
          xm_d          = b1_q[6] ? 9'd0 : {b1_q[4], b2_q};
          ym_d          = b1_q[7] ? 9'd0 : {b1_q[5], rx_data};
          btnm_d        = b1_q[2:0];
          m_done_tick_d = 1'b1;
          state_d       = ST_PKT1;
        end else if (tc_s) begin
          state_d = ST_PKT1;
        end else begin
          state_d = ST_PKT3;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_SEND_RST;
      end
    endcase

    if (fail_s) begin
      retry_d = retry_q + RW'(1);
      if (retry_q == RW'(MAX_RETRY - 1)) begin
        state_d = ST_FAIL;
        err_d   = 1'b1;
      end else begin
        state_d = ST_SEND_RST;
      end
    end else begin
      retry_d = retry_q;
    end

    rx_en_d = rx_en_of(state_d);
  end

  // a failed attempt restarts in the same state it left, so it must clear the timer explicitly
  assign timer_clr_s = (state_d != state_q) || fail_s;
  assign gap_sel_s   = (state_q == ST_PKT2) || (state_q == ST_PKT3);

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SEND_RST;
      retry_q       <= '0;
      tx_req_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      rx_en_q       <= 1'b0;
      init_done_q   <= 1'b0;
      err_q         <= 1'b0;
      xm_q          <= 9'd0;
      ym_q          <= 9'd0;
      btnm_q        <= 3'd0;
      m_done_tick_q <= 1'b0;
      b1_q          <= 8'h00;
      b2_q          <= 8'h00;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      tx_req_q      <= tx_req_d;
      tx_data_q     <= tx_data_d;
      rx_en_q       <= rx_en_d;
      init_done_q   <= init_done_d;
      err_q         <= err_d;
      xm_q          <= xm_d;
      ym_q          <= ym_d;
      btnm_q        <= btnm_d;
      m_done_tick_q <= m_done_tick_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
    end
  end

  assign rx_en       = rx_en_q;
  assign tx_req      = tx_req_q;
  assign tx_data     = tx_data_q;
  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btnm        = btnm_q;
  assign m_done_tick = m_done_tick_q;
  assign init_done   = init_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init handshake, packet table, resync, gap/init timeouts, failure.
module tb_ps2_mouse_ctrl;

  localparam int TO_CYC  = 300;
  localparam int GAP     = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       rx_en;
  logic       tx_idle = 1'b1;
  logic       tx_done_tick = 1'b0;
  logic       tx_req;
  logic [7:0] tx_data;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  logic       init_done;
  logic       err;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;
  int tick_cnt = 0;

  ps2_mouse_ctrl #(
    .TIMEOUT_CYC (TO_CYC),
    .GAP_CYC     (GAP),
    .MAX_RETRY   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .rx_en        (rx_en),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .xm           (xm),
    .ym           (ym),
    .btnm         (btnm),
    .m_done_tick  (m_done_tick),
    .init_done    (init_done),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_req) tx_cnt = tx_cnt + 1;
    if (m_done_tick) tick_cnt = tick_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
  } pkt_vec_t;

  pkt_vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic wait_req(input int bound, output logic [7:0] d, output logic got);
    got = 1'b0;
    d   = 8'h00;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx_req) begin
        d   = tx_data;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rx_en", {31'd0, rx_en}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    reset = 1'b1;
  endtask

  // Everything after the reset command has been issued.
  task automatic init_after_ff();
    logic [7:0] d;
    logic       got;
    chk("rx_en_during_tx", {31'd0, rx_en}, 32'd0);
    // tx done and a stray rx byte together: only the tx strobe matters here
    @(negedge clk);
    tx_done_tick = 1'b1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h55;
    @(negedge clk);
    tx_done_tick = 1'b0;
    rx_done_tick = 1'b0;
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_req(20, d, got);
    chk("en_req_seen", {31'd0, got}, 32'd1);
    chk("en_cmd", {24'd0, d}, 32'h0000_00F4);
    pulse_tx_done();
    send_rx(8'hFA);
    repeat (2) @(negedge clk);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_rx(a);
    send_rx(b);
    send_rx(c);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       got;
    int         tx_base;
    int         tick_base;

    vecs[0] = '{8'h19, 8'h05, 8'hFE, 9'h105, 9'h0FE, 3'b001};
    vecs[1] = '{8'h4A, 8'h7F, 8'h03, 9'h000, 9'h003, 3'b010};
    vecs[2] = '{8'h08, 8'h10, 8'h20, 9'h010, 9'h020, 3'b000};
    vecs[3] = '{8'h38, 8'hFF, 8'hFF, 9'h1FF, 9'h1FF, 3'b000};
    vecs[4] = '{8'h8F, 8'h12, 8'h34, 9'h012, 9'h000, 3'b111};
    vecs[5] = '{8'hCC, 8'h55, 8'h66, 9'h000, 9'h000, 3'b100};

    do_reset();
    chk("rst_xm", {23'd0, xm}, 32'd0);
    chk("rst_tick", {31'd0, m_done_tick}, 32'd0);
    tx_base = tx_cnt;
    tick_base = tick_cnt;

    // nominal init
    wait_req(20, d, got);
    chk("rst_req_seen", {31'd0, got}, 32'd1);
    chk("rst_cmd", {24'd0, d}, 32'h0000_00FF);
    init_after_ff();
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("init_err", {31'd0, err}, 32'd0);
    chk("init_rx_en", {31'd0, rx_en}, 32'd1);
    chk("init_tx_pulses", tx_cnt - tx_base, 32'd2);
    chk("no_tick_in_init", tick_cnt - tick_base, 32'd0);

    // packet table
    for (int i = 0; i < 6; i++) begin
      tick_base = tick_cnt;
      pkt(vecs[i].b1, vecs[i].b2, vecs[i].b3);
      chk($sformatf("vec%0d_ticks", i), tick_cnt - tick_base, 32'd1);
      chk($sformatf("vec%0d_xm", i), {23'd0, xm}, {23'd0, vecs[i].xm});
      chk($sformatf("vec%0d_ym", i), {23'd0, ym}, {23'd0, vecs[i].ym});
      chk($sformatf("vec%0d_btn", i), {29'd0, btnm}, {29'd0, vecs[i].btn});
    end

    // resync: leading byte without bit 3 is dropped
    tick_base = tick_cnt;
    send_rx(8'h02);
    pkt(8'h08, 8'h10, 8'h20);
    chk("resync_ticks", tick_cnt - tick_base, 32'd1);
    chk("resync_xm", {23'd0, xm}, 32'h010);
    chk("resync_ym", {23'd0, ym}, 32'h020);
    chk("resync_btn", {29'd0, btnm}, 32'd0);

    // gap timeout drops the partial packet
    tick_base = tick_cnt;
    send_rx(8'h08);
    send_rx(8'h10);
    repeat (GAP + 5) @(negedge clk);
    chk("gap_no_tick", tick_cnt - tick_base, 32'd0);
    chk("gap_xm_held", {23'd0, xm}, 32'h010);
    pkt(8'h08, 8'h01, 8'h02);
    chk("gap_ticks", tick_cnt - tick_base, 32'd1);
    chk("gap_xm", {23'd0, xm}, 32'h001);
    chk("gap_ym", {23'd0, ym}, 32'h002);

    // a gap just under the limit still completes the packet
    tick_base = tick_cnt;
    send_rx(8'h08);
    repeat (GAP - 10) @(negedge clk);
    send_rx(8'h03);
    repeat (GAP - 10) @(negedge clk);
    send_rx(8'h04);
    repeat (2) @(negedge clk);
    chk("slow_ticks", tick_cnt - tick_base, 32'd1);
    chk("slow_xm", {23'd0, xm}, 32'h003);
    chk("slow_ym", {23'd0, ym}, 32'h004);

    // init response timeout: reset command is re-issued, then init completes
    do_reset();
    wait_req(20, d, got);
    chk("to_first_ff", {24'd0, d}, 32'h0000_00FF);
    pulse_tx_done();
    repeat (TO_CYC / 2) @(negedge clk);
    chk("to_not_early", {31'd0, tx_req}, 32'd0);
    wait_req(TO_CYC + 50, d, got);
    chk("to_retry_seen", {31'd0, got}, 32'd1);
    chk("to_retry_ff", {24'd0, d}, 32'h0000_00FF);
    init_after_ff();
    chk("to_init_done", {31'd0, init_done}, 32'd1);

    // init failure: device rejects every reset
    do_reset();
    tx_base = tx_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_req(20, d, got);
      chk($sformatf("fail_ff%0d", k), {23'd0, got, d}, 32'h0000_01FF);
      pulse_tx_done();
      send_rx(8'hFE);
    end
    repeat (50) @(negedge clk);
    chk("fail_err", {31'd0, err}, 32'd1);
    chk("fail_rx_en", {31'd0, rx_en}, 32'd0);
    chk("fail_init_done", {31'd0, init_done}, 32'd0);
    chk("fail_tx_count", tx_cnt - tx_base, 32'd3);

    do_reset();
    wait_req(20, d, got);
    chk("post_fail_ff", {23'd0, got, d}, 32'h0000_01FF);
    chk("post_fail_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
